tcam_arbiter: RTL and testbench
===============================

TCAM_ARBITER -- requirements
Module: tcam_arbiter

Interface
REQ-001 SHALL have parameters: ID_Width, default 4, packet/destination ID width; AddressSize, default 4, TCAM address width; Bits, default 8, TCAM word width (= 2*ID_Width); Words, default 16, TCAM entries; NUM_REQ, default 4, lookup requesters.
REQ-002 SHALL use one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-003 Ports, requester side:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- lk_valid  in  NUM_REQ  lookup request per requester
- lk_id  in  NUM_REQ*ID_Width  packet ID per requester; requester r at bits [r*ID_Width +: ID_Width]
- lk_ready  out  NUM_REQ  one-hot grant
- rsp_valid  out  1  response pulse
- rsp_src  out  clog2(NUM_REQ)  granted requester index
- rsp_hit  out  1  hit and valid entry
- rsp_dst  out  ID_Width  destination ID, 0 on miss
- wr_valid  in  1  config write request
- wr_ready  out  1  write accepted
- wr_addr  in  AddressSize  write address
- wr_data  in  Bits  write data
- wr_mskb  in  Bits  write mask
- wr_vbi  in  1  write valid bit
REQ-004 Ports, TCAM side:
- cam_cs, cam_flush, cam_vbe, cam_dcs, cam_wr, cam_rd, cam_cmp  out  1 each  macro controls
- cam_di, cam_mskb  out  Bits  data and mask
- cam_vbi  out  1  valid-bit input
- cam_a  out  AddressSize  address
- cam_do  in  Bits  read data
- cam_vbo, cam_hit  in  1 each  valid out, hit
- cam_hitline  in  Words  per-entry match

Function
REQ-005 FSM states SHALL be IDLE, CMP, CMP_RD, RSP, WRITE and FLUSH; all TCAM outputs SHALL be registered.
REQ-006 Priority in IDLE SHALL be flush > write > lookup.
- Lookup grants SHALL be round-robin.
- The pointer SHALL advance to granted index+1, wrapping at NUM_REQ.
REQ-007 Handshake: a transfer SHALL occur when lk_valid[r] && lk_ready[r]; lk_ready SHALL be high only in IDLE with no write or flush pending, and at most one bit high.
REQ-008 Lookup sequence:
- Cycle 0 (handshake): latch lk_id and the index.
- Cycle 1, CMP: cs=1, cmp=1, di={id, 0}, mskb={ones, zeros}, vbe=dcs=0.
- Cycle 2, CMP_RD: cs=1, rd=1, vbe=dcs=1, a=index of the lowest set cam_hitline bit (0 if none); latch cam_hit.
- Cycle 3, RSP: rsp_valid=1 for one cycle.
REQ-009 Response: rsp_hit = latched hit && cam_vbo; rsp_dst = cam_do[ID_Width-1:0] when rsp_hit, else 0.
- rsp_src = granted index.
- No backpressure on the response.
- Back-to-back lookups start every 4 cycles.
REQ-010 Write: wr_ready SHALL pulse in IDLE for one cycle; WRITE SHALL last one cycle with cs=wr=vbe=dcs=1, di=wr_data, mskb=wr_mskb, vbi=wr_vbi, a=wr_addr; then return to IDLE.
REQ-011 In IDLE, cs and all strobes SHALL be 0, and di, mskb and a SHALL be 0.
REQ-012 Requests arriving mid-sequence SHALL wait; a lookup in progress SHALL never be preempted.
REQ-013 Simultaneous wr_valid and lk_valid SHALL grant the write, leaving the round-robin pointer unchanged.

Reset
REQ-014 Reset SHALL take effect immediately:
- state=IDLE, pointer=0, all outputs 0.
- An in-flight lookup SHALL be dropped with no rsp_valid.
REQ-015 After rst_n deasserts, the first grant SHALL occur no earlier than the first clk edge.

Configuration
REQ-016 With TCAM_ARB_FLUSH_EN defined:
- Add flush_req (in, 1) and flush_done (out, 1).
- A flush request SHALL drive one cycle of FLUSH (cs=1, flush=1), then pulse flush_done for one cycle.
REQ-017 Without TCAM_ARB_FLUSH_EN, the ports and the FLUSH state SHALL be absent and cam_flush SHALL be tied to 0.

Structure
REQ-018 The state enum, the default widths and the mode/strobe constants SHALL live in package tcam_pkg.
REQ-019 The round-robin grant SHALL be a sub-module rr_arbiter (NUM_REQ requests, one-hot grant, advance-on-accept input).

Verification
REQ-020 The bench SHALL cover:
- Write addr 3, data 8'h5A, mskb 8'hF0, vbi=1; then lookup id 4'h5 from requester 2 -> cam_a=3 in CMP_RD, rsp_valid at cycle 3, rsp_src=2, rsp_hit=1, rsp_dst=4'hA.
- Lookup id 4'h7 with no match -> rsp_hit=0, rsp_dst=0, cam_a=0.
- All four requesters valid continuously -> grants 0,1,2,3,0 at 4-cycle spacing.
- wr_valid and lk_valid[1] in the same cycle -> WRITE first; requester 1 granted 2 cycles later.
- rst_n low during CMP_RD -> outputs 0 immediately; no rsp_valid.
- With TCAM_ARB_FLUSH_EN, flush_req during a lookup -> lookup completes, then FLUSH, then flush_done; a following lookup for 4'h5 misses.

Source files
------------

// File: rtl/tcam_pkg.sv
// tcam_pkg: shared widths, FSM state encoding and TCAM strobe bundles for tcam_arbiter.
// Revision 1.0
`default_nettype none

package tcam_pkg;

  localparam int DEF_ID_WIDTH     = 4;
  localparam int DEF_ADDRESS_SIZE = 4;
  localparam int DEF_BITS         = 8;
  localparam int DEF_WORDS        = 16;
  localparam int DEF_NUM_REQ      = 4;

`ifdef TCAM_ARB_FLUSH_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMP    = 3'd1,
    S_CMP_RD = 3'd2,
    S_RSP    = 3'd3,
    S_WRITE  = 3'd4,
    S_FLUSH  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMP    = 3'd1,
    S_CMP_RD = 3'd2,
    S_RSP    = 3'd3,
    S_WRITE  = 3'd4
  } state_t;
`endif

  // Per-mode TCAM strobe sets; the flush strobe is kept separately so it can vanish.
  typedef struct packed {
    logic cs;
    logic vbe;
    logic dcs;
    logic wr;
    logic rd;
    logic cmp;
  } cam_ctl_t;

  localparam cam_ctl_t CTL_OFF    = '{cs: 1'b0, vbe: 1'b0, dcs: 1'b0, wr: 1'b0, rd: 1'b0, cmp: 1'b0};
  localparam cam_ctl_t CTL_CMP    = '{cs: 1'b1, vbe: 1'b0, dcs: 1'b0, wr: 1'b0, rd: 1'b0, cmp: 1'b1};
  localparam cam_ctl_t CTL_CMP_RD = '{cs: 1'b1, vbe: 1'b1, dcs: 1'b1, wr: 1'b0, rd: 1'b1, cmp: 1'b0};
  localparam cam_ctl_t CTL_WRITE  = '{cs: 1'b1, vbe: 1'b1, dcs: 1'b1, wr: 1'b1, rd: 1'b0, cmp: 1'b0};
  localparam cam_ctl_t CTL_FLUSH  = '{cs: 1'b1, vbe: 1'b0, dcs: 1'b0, wr: 1'b0, rd: 1'b0, cmp: 1'b0};

endpackage

`default_nettype wire

// File: rtl/tcam_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant; pointer moves past the winner on accept.
// Revision 1.0
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int unsigned   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && found) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tcam_arbiter.sv
// tcam_arbiter: shares one TCAM between round-robin lookups, config writes and
// (with TCAM_ARB_FLUSH_EN) flushes. Revision 1.0
`default_nettype none

module tcam_arbiter
  import tcam_pkg::*;
#(
  parameter int ID_Width    = DEF_ID_WIDTH,
  parameter int AddressSize = DEF_ADDRESS_SIZE,
  parameter int Bits        = DEF_BITS,
  parameter int Words       = DEF_WORDS,
  parameter int NUM_REQ     = DEF_NUM_REQ
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            lk_valid,
  input  logic [NUM_REQ*ID_Width-1:0]   lk_id,
  output logic [NUM_REQ-1:0]            lk_ready,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_src,
  output logic                          rsp_hit,
  output logic [ID_Width-1:0]           rsp_dst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [AddressSize-1:0]        wr_addr,
  input  logic [Bits-1:0]               wr_data,
  input  logic [Bits-1:0]               wr_mskb,
  input  logic                          wr_vbi,
`ifdef TCAM_ARB_FLUSH_EN
  input  logic                          flush_req,
  output logic                          flush_done,
`endif
  output logic                          cam_cs,
  output logic                          cam_flush,
  output logic                          cam_vbe,
  output logic                          cam_dcs,
  output logic                          cam_wr,
  output logic                          cam_rd,
  output logic                          cam_cmp,
  output logic [Bits-1:0]               cam_di,
  output logic [Bits-1:0]               cam_mskb,
  output logic                          cam_vbi,
  output logic [AddressSize-1:0]        cam_a,
  input  logic [Bits-1:0]               cam_do,
  input  logic                          cam_vbo,
  input  logic                          cam_hit,
  input  logic [Words-1:0]              cam_hitline
);

  localparam int SRC_W = $clog2(NUM_REQ);

  state_t               state;
  cam_ctl_t             ctl;
  logic                 lat_hit;
  logic [SRC_W-1:0]     lat_src;
  logic [NUM_REQ-1:0]   grant;
  logic [SRC_W-1:0]     grant_idx;
  logic                 flush_go;
  logic                 lk_en;
  logic                 accept;
  logic [ID_Width-1:0]  sel_id;
  logic [AddressSize-1:0] hit_idx;
  logic                 rsp_hit_next;
  logic                 unused_do_bits;

  assign unused_do_bits = ^cam_do[Bits-1:ID_Width];

`ifdef TCAM_ARB_FLUSH_EN
  logic flush_pend;
  logic flush_q;
  assign flush_go  = flush_req | flush_pend;
  assign cam_flush = flush_q;
`else
  assign flush_go  = 1'b0;
  assign cam_flush = 1'b0;
`endif

  assign lk_en    = (state == S_IDLE) && !wr_valid && !flush_go;
  assign lk_ready = lk_en ? grant : '0;
  assign accept   = lk_en && (|grant);
  assign wr_ready = (state == S_IDLE) && wr_valid && !flush_go;
  assign sel_id   = lk_id[grant_idx*ID_Width +: ID_Width];

  rr_arbiter #(.N(NUM_REQ), .IW(SRC_W)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (lk_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Lowest matching entry wins the read address.
  always_comb begin
    hit_idx = '0;
    for (int i = Words - 1; i >= 0; i--) begin
      if (cam_hitline[i]) hit_idx = AddressSize'(i);
    end
  end

  assign rsp_hit_next = lat_hit && cam_vbo;

  assign cam_cs  = ctl.cs;
  assign cam_vbe = ctl.vbe;
  assign cam_dcs = ctl.dcs;
  assign cam_wr  = ctl.wr;
  assign cam_rd  = ctl.rd;
  assign cam_cmp = ctl.cmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ctl       <= CTL_OFF;
      cam_di    <= '0;
      cam_mskb  <= '0;
      cam_vbi   <= 1'b0;
      cam_a     <= '0;
      lat_hit   <= 1'b0;
      lat_src   <= '0;
      rsp_valid <= 1'b0;
      rsp_src   <= '0;
      rsp_hit   <= 1'b0;
      rsp_dst   <= '0;
`ifdef TCAM_ARB_FLUSH_EN
      flush_pend <= 1'b0;
      flush_q    <= 1'b0;
      flush_done <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef TCAM_ARB_FLUSH_EN
      flush_q    <= 1'b0;
      flush_done <= 1'b0;
      flush_pend <= flush_pend | flush_req;
`endif
      case (state)
        S_IDLE: begin
          ctl      <= CTL_OFF;
          cam_di   <= '0;
          cam_mskb <= '0;
          cam_vbi  <= 1'b0;
          cam_a    <= '0;
`ifdef TCAM_ARB_FLUSH_EN
          if (flush_go) begin
            state      <= S_FLUSH;
            ctl        <= CTL_FLUSH;
            flush_q    <= 1'b1;
            flush_pend <= 1'b0;
          end else
`endif
          if (wr_valid) begin
            state    <= S_WRITE;
            ctl      <= CTL_WRITE;
            cam_di   <= wr_data;
            cam_mskb <= wr_mskb;
            cam_vbi  <= wr_vbi;
            cam_a    <= wr_addr;
          end else if (accept) begin
            state    <= S_CMP;
            ctl      <= CTL_CMP;
            cam_di   <= {sel_id, {ID_Width{1'b0}}};
            cam_mskb <= {{ID_Width{1'b1}}, {ID_Width{1'b0}}};
            lat_src  <= grant_idx;
          end
        end
        S_CMP: begin
          state    <= S_CMP_RD;
          ctl      <= CTL_CMP_RD;
          cam_di   <= '0;
          cam_mskb <= '0;
          cam_a    <= hit_idx;
          lat_hit  <= cam_hit;
        end
        S_CMP_RD: begin
          state     <= S_RSP;
          ctl       <= CTL_OFF;
          cam_a     <= '0;
          rsp_valid <= 1'b1;
          rsp_src   <= lat_src;
          rsp_hit   <= rsp_hit_next;
          rsp_dst   <= rsp_hit_next ? cam_do[ID_Width-1:0] : '0;
        end
        S_RSP: begin
          state <= S_IDLE;
        end
        S_WRITE: begin
          state    <= S_IDLE;
          ctl      <= CTL_OFF;
          cam_di   <= '0;
          cam_mskb <= '0;
          cam_vbi  <= 1'b0;
          cam_a    <= '0;
        end
`ifdef TCAM_ARB_FLUSH_EN
        S_FLUSH: begin
          state      <= S_IDLE;
          ctl        <= CTL_OFF;
          flush_done <= 1'b1;
        end
`endif
        default: begin
          state <= S_IDLE;
          ctl   <= CTL_OFF;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tcam_arbiter.sv
// tb_tcam_arbiter: directed checks of tcam_arbiter against a behavioural TCAM.
`default_nettype none

module tb_tcam_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  lk_valid;
  logic [15:0] lk_id;
  logic [3:0]  lk_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_src;
  logic        rsp_hit;
  logic [3:0]  rsp_dst;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data, wr_mskb;
  logic        wr_vbi;
  logic        cam_cs, cam_flush, cam_vbe, cam_dcs, cam_wr, cam_rd, cam_cmp;
  logic [7:0]  cam_di, cam_mskb, cam_do;
  logic        cam_vbi, cam_vbo, cam_hit;
  logic [3:0]  cam_a;
  logic [15:0] cam_hitline;
`ifdef TCAM_ARB_FLUSH_EN
  logic        flush_req, flush_done;
`endif

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  tcam_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_id(lk_id), .lk_ready(lk_ready),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_hit(rsp_hit), .rsp_dst(rsp_dst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mskb(wr_mskb), .wr_vbi(wr_vbi),
`ifdef TCAM_ARB_FLUSH_EN
    .flush_req(flush_req), .flush_done(flush_done),
`endif
    .cam_cs(cam_cs), .cam_flush(cam_flush), .cam_vbe(cam_vbe), .cam_dcs(cam_dcs),
    .cam_wr(cam_wr), .cam_rd(cam_rd), .cam_cmp(cam_cmp), .cam_di(cam_di),
    .cam_mskb(cam_mskb), .cam_vbi(cam_vbi), .cam_a(cam_a), .cam_do(cam_do),
    .cam_vbo(cam_vbo), .cam_hit(cam_hit), .cam_hitline(cam_hitline)
  );

  // Behavioural TCAM: compare answers in the cmp cycle, read answers in the rd cycle.
  bit [7:0] m_data [16];
  bit [7:0] m_mskb [16];
  bit       m_val  [16];

  always @(posedge clk) begin
    if (cam_cs && cam_wr) begin
      m_data[cam_a] <= cam_di;
      m_mskb[cam_a] <= cam_mskb;
      m_val[cam_a]  <= cam_vbi;
    end
    if (cam_cs && cam_flush) begin
      for (int i = 0; i < 16; i++) m_val[i] <= 1'b0;
    end
  end

  always_comb begin
    cam_hitline = '0;
    for (int i = 0; i < 16; i++) begin
      if (cam_cmp && m_val[i] && (((m_data[i] ^ cam_di) & m_mskb[i] & cam_mskb) == 8'h00))
        cam_hitline[i] = 1'b1;
    end
  end

  assign cam_hit = |cam_hitline;
  assign cam_do  = cam_rd ? m_data[cam_a] : 8'h00;
  assign cam_vbo = cam_rd && m_val[cam_a];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int g_idx [$];
  int g_cyc [$];
  bit saw_rsp;

  initial begin
    rst_n = 1'b0; lk_valid = '0; lk_id = '0; wr_valid = 1'b0; wr_addr = '0;
    wr_data = '0; wr_mskb = '0; wr_vbi = 1'b0;
`ifdef TCAM_ARB_FLUSH_EN
    flush_req = 1'b0;
`endif
    tick(); #1;
    check("reset_cs",        32'(cam_cs),    32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_cam_a",     32'(cam_a),     32'h0);
    check("reset_lk_ready",  32'(lk_ready),  32'h0);
    tick(); rst_n = 1'b1;

    // Write entry 3: key nibble 5 (cared), destination A
    tick(); wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 8'h5A; wr_mskb = 8'hF0; wr_vbi = 1'b1;
    #1 check("wr_ready", 32'(wr_ready), 32'h1);
    tick(); wr_valid = 1'b0;
    check("write_strobes", {cam_cs, cam_wr, cam_vbe, cam_dcs, cam_rd, cam_cmp}, 6'b111100);
    check("write_a",       32'(cam_a),                        32'h3);
    check("write_di_mskb", {cam_di, cam_mskb, 7'd0, cam_vbi}, {8'h5A, 8'hF0, 8'h01});
    tick();
    check("idle_quiet", {cam_cs, cam_wr, cam_di, cam_mskb, cam_a}, 32'h0);

    // Lookup id 5 from requester 2 -> hit on entry 3
    lk_valid = 4'b0100; lk_id = 16'h0500;
    #1 check("lk_ready_r2", 32'(lk_ready), 32'h4);
    tick(); lk_valid = '0;
    check("cmp_strobes", {cam_cs, cam_cmp, cam_rd, cam_vbe, cam_dcs}, 5'b11000);
    check("cmp_di_mskb", {cam_di, cam_mskb}, 16'h50F0);
    tick();
    check("cmprd_strobes", {cam_cs, cam_rd, cam_vbe, cam_dcs, cam_cmp}, 5'b11110);
    check("cmprd_a",       32'(cam_a), 32'h3);
    check("rsp_before",    32'(rsp_valid), 32'h0);
    tick();
    check("hit_rsp", {rsp_valid, rsp_hit, 2'b00, rsp_src, rsp_dst}, {1'b1, 1'b1, 2'b00, 2'd2, 4'hA});
    tick();
    check("rsp_pulse_end", 32'(rsp_valid), 32'h0);

    // Lookup id 7 from requester 0 -> miss
    lk_valid = 4'b0001; lk_id = 16'h0007;
    #1 check("lk_ready_r0", 32'(lk_ready), 32'h1);
    tick(); lk_valid = '0;
    tick();
    check("miss_a", 32'(cam_a), 32'h0);
    tick();
    check("miss_rsp", {rsp_valid, rsp_hit, 2'b00, rsp_src, rsp_dst}, {1'b1, 1'b0, 2'b00, 2'd0, 4'h0});

    // Write and requester-1 lookup together: write wins, lookup granted two cycles later
    tick(); wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 8'h33; wr_mskb = 8'hFF; wr_vbi = 1'b1;
    lk_valid = 4'b0010; lk_id = 16'h0070;
    #1 check("both_wr_ready", {wr_ready, lk_ready}, 5'b10000);
    tick(); wr_valid = 1'b0;
    #1 check("both_write_first", {cam_wr, lk_ready}, 5'b10000);
    tick(); #1;
    check("both_lk_granted", 32'(lk_ready), 32'h2);
    tick(); lk_valid = '0;
    check("both_cmp", 32'(cam_cmp), 32'h1);

    // Asynchronous reset in the middle of CMP_RD
    tick();
    check("pre_reset_rd", 32'(cam_rd), 32'h1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {cam_cs, cam_rd, cam_vbe, cam_dcs, cam_a}, 32'h0);
    tick(); rst_n = 1'b1;
    saw_rsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("dropped_rsp", 32'(saw_rsp), 32'h0);

    // All requesters valid: grants 0,1,2,3,0 every 4 cycles
    lk_valid = 4'b1111; lk_id = 16'h7777;
    for (int c = 0; c <= 16; c++) begin
      if (c != 0) tick();
      #1;
      if (!$onehot0(lk_ready)) check("onehot", 32'(lk_ready), 32'h0);
      if (lk_ready != 4'b0000) begin
        g_idx.push_back($clog2(lk_ready));
        g_cyc.push_back(c);
      end
      if (c == 16) lk_valid = '0;
    end
    check("rr_count", 32'(g_idx.size()), 32'd5);
    for (int k = 0; k < 5 && k < g_idx.size(); k++) begin
      check("rr_idx", 32'(g_idx[k]), 32'(k % 4));
      check("rr_cyc", 32'(g_cyc[k]), 32'(k * 4));
    end
    tick(); tick();

`ifdef TCAM_ARB_FLUSH_EN
    // Flush requested mid-lookup: lookup completes, then flush, then entry 3 gone
    lk_valid = 4'b0001; lk_id = 16'h0005;
    #1 check("fl_lk_ready", 32'(lk_ready), 32'h1);
    tick(); lk_valid = '0; flush_req = 1'b1;
    tick(); flush_req = 1'b0;
    check("fl_no_preempt", {cam_rd, cam_flush}, 2'b10);
    tick();
    check("fl_lookup_hit", {rsp_valid, rsp_hit, rsp_dst}, {1'b1, 1'b1, 4'hA});
    tick();
    check("fl_idle", {cam_flush, lk_ready}, 5'b00000);
    tick();
    check("fl_flush", {cam_cs, cam_flush}, 2'b11);
    tick();
    check("fl_done", {flush_done, cam_flush}, 2'b10);
    lk_valid = 4'b0001; lk_id = 16'h0005;
    tick(); lk_valid = '0;
    check("fl_done_pulse", 32'(flush_done), 32'h0);
    tick(); tick();
    check("fl_after_miss", {rsp_valid, rsp_hit, rsp_dst}, {1'b1, 1'b0, 4'h0});
`else
    check("flush_tied", 32'(cam_flush), 32'h0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
